// File: rtl/mem_interconnect_if.sv
// Bus bundle between the core LSU port, the interconnect and the slave channels.
// The interconnect uses the "slave" modport (it serves the core and drives the
// slave channels); the core/environment side uses "master".
interface mem_interconnect_if #(
    parameter int XLEN     = 32,
    parameter int N_SLAVES = 4
);
    // Core-facing request/response
    logic                     mem_req;
    logic                     mem_we;
    logic [XLEN-1:0]          mem_addr;
    logic [XLEN/8-1:0]        mem_byteen;
    logic [XLEN-1:0]          mem_wdata;
    logic                     mem_gnt;
    logic                     mem_rvalid;
    logic [XLEN-1:0]          mem_rdata;
    logic                     mem_err;

    // Slave-facing channels
    logic [N_SLAVES-1:0]      s_req;
    logic                     s_we;
    logic [XLEN-1:0]          s_addr;
    logic [XLEN/8-1:0]        s_byteen;
    logic [XLEN-1:0]          s_wdata;
    logic [N_SLAVES-1:0]      s_ack;
    logic [N_SLAVES-1:0]      s_err;
    logic [N_SLAVES*XLEN-1:0] s_rdata;

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err,
        output s_req, s_we, s_addr, s_byteen, s_wdata,
        input  s_ack, s_err, s_rdata
    );

    modport master (
        output mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
        input  s_req, s_we, s_addr, s_byteen, s_wdata,
        output s_ack, s_err, s_rdata
    );
endinterface

// File: rtl/mem_interconnect.sv
// Single-outstanding data-bus interconnect: decodes the core request onto one of
// N_SLAVES channels, waits for that slave's ack (with timeout), and returns a
// registered response. Unmapped and misaligned accesses are answered locally.
module mem_interconnect #(
    parameter int                         XLEN        = 32,
    parameter int                         N_SLAVES    = 4,
    parameter logic [N_SLAVES*XLEN-1:0]   SLV_BASE    = {32'h3000_0000, 32'h2000_0000,
                                                         32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*XLEN-1:0]   SLV_MASK    = {4{32'hF000_0000}},
    parameter int                         TIMEOUT     = 16,
    parameter int                         ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_interconnect_if.slave bus
);
    localparam int BE_W  = XLEN / 8;
    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [SEL_W-1:0]    sel_reg, sel_next;
    logic [N_SLAVES-1:0] s_req_reg, s_req_next;
    logic                s_we_reg, s_we_next;
    logic [XLEN-1:0]     s_addr_reg, s_addr_next;
    logic [BE_W-1:0]     s_byteen_reg, s_byteen_next;
    logic [XLEN-1:0]     s_wdata_reg, s_wdata_next;
    logic                rvalid_reg, rvalid_next;
    logic [XLEN-1:0]     rdata_reg, rdata_next;
    logic                err_reg, err_next;

    logic [N_SLAVES-1:0] hit;
    logic [XLEN-1:0]     slv_rdata [N_SLAVES];
    logic [SEL_W-1:0]    dec_idx;
    logic                dec_hit;
    logic                misalign;
    logic                gnt;
    logic                ack_sel;
    logic                err_sel;
    logic [XLEN-1:0]     rdata_sel;

    // Per-slave address match and unpacking of the packed read-data bus
    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slv
            assign hit[gi] = ((bus.mem_addr & SLV_MASK[gi*XLEN +: XLEN]) ==
                              SLV_BASE[gi*XLEN +: XLEN]);
            assign slv_rdata[gi] = bus.s_rdata[gi*XLEN +: XLEN];
        end
    endgenerate

    // Priority encode the hits; scanning downwards lets the lowest index win on overlap
    always_comb begin
        dec_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                dec_idx = SEL_W'(i);
            end
        end
    end

    assign dec_hit  = |hit;
    // Full-word access must be word aligned; partial byte-enable accesses are passed through
    assign misalign = (ALIGN_CHECK != 0) && (bus.mem_addr[1:0] != 2'b00) && (&bus.mem_byteen);

    // Grant is the only combinational output; suppressed while reset is asserted so a
    // request is never accepted on the same edge that discards it
    assign gnt = bus.mem_req && (state_reg == ST_IDLE) && !rst;

    // Only the selected slave's handshake is ever observed
    assign ack_sel   = bus.s_ack[sel_reg];
    assign err_sel   = bus.s_err[sel_reg];
    assign rdata_sel = slv_rdata[sel_reg];

    // Next-state and next-output logic for the transaction FSM
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        sel_next      = sel_reg;
        s_req_next    = '0;
        s_we_next     = s_we_reg;
        s_addr_next   = s_addr_reg;
        s_byteen_next = s_byteen_reg;
        s_wdata_next  = s_wdata_reg;
        rvalid_next   = 1'b0;
        rdata_next    = '0;
        err_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (gnt) begin
                    sel_next      = dec_idx;
                    s_we_next     = bus.mem_we;
                    s_addr_next   = bus.mem_addr;
                    s_byteen_next = bus.mem_byteen;
                    s_wdata_next  = bus.mem_wdata;
                    if (dec_hit && !misalign) begin
                        state_next = ST_ISSUE;
                        s_req_next = N_SLAVES'(1) << dec_idx;
                    end else begin
                        // Answered locally: error response, no slave is touched
                        state_next  = ST_RESP;
                        rvalid_next = 1'b1;
                        err_next    = 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                if (ack_sel) begin
                    state_next  = ST_RESP;
                    rvalid_next = 1'b1;
                    err_next    = err_sel;
                    rdata_next  = (s_we_reg || err_sel) ? '0 : rdata_sel;
                end else begin
                    state_next = ST_WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end

            ST_WAIT: begin
                if (ack_sel) begin
                    state_next  = ST_RESP;
                    rvalid_next = 1'b1;
                    err_next    = err_sel;
                    rdata_next  = (s_we_reg || err_sel) ? '0 : rdata_sel;
                end else if (cnt_reg == CNT_LAST) begin
                    // Slave gave up on: report an error, any later ack is ignored
                    state_next  = ST_RESP;
                    rvalid_next = 1'b1;
                    err_next    = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_RESP: begin
                // Response is on the bus this cycle; release the broadcast signals
                state_next    = ST_IDLE;
                cnt_next      = '0;
                s_we_next     = 1'b0;
                s_addr_next   = '0;
                s_byteen_next = '0;
                s_wdata_next  = '0;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            sel_reg      <= '0;
            s_req_reg    <= '0;
            s_we_reg     <= 1'b0;
            s_addr_reg   <= '0;
            s_byteen_reg <= '0;
            s_wdata_reg  <= '0;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            sel_reg      <= sel_next;
            s_req_reg    <= s_req_next;
            s_we_reg     <= s_we_next;
            s_addr_reg   <= s_addr_next;
            s_byteen_reg <= s_byteen_next;
            s_wdata_reg  <= s_wdata_next;
            rvalid_reg   <= rvalid_next;
            rdata_reg    <= rdata_next;
            err_reg      <= err_next;
        end
    end

    assign bus.mem_gnt    = gnt;
    assign bus.mem_rvalid = rvalid_reg;
    assign bus.mem_rdata  = rdata_reg;
    assign bus.mem_err    = err_reg;
    assign bus.s_req      = s_req_reg;
    assign bus.s_we       = s_we_reg;
    assign bus.s_addr     = s_addr_reg;
    assign bus.s_byteen   = s_byteen_reg;
    assign bus.s_wdata    = s_wdata_reg;
endmodule
